// File: rtl/aqua_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package   : aqua_pkg                                                  |
// | Brief     : Shared core types: regfile writeback bundle and requests. |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
package aqua_pkg;

    localparam int WB_NUM_REQ = 4;

    typedef struct packed {
        logic        wren_instr1;
        logic        wren_instr2;
        logic [4:0]  rd_addr_instr1;
        logic [4:0]  rd_addr_instr2;
        logic [31:0] rd_data_instr1;
        logic [31:0] rd_data_instr2;
    } writeback_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd_addr;
        logic [31:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_rr_pick2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module    : rr_pick2                                                  |
// | Brief     : Rotating find-first-two with same-destination exclusion.  |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [PTR_W-1:0]        i_ptr,
    input  logic [NUM_REQ-1:0]      i_valid,
    input  logic [NUM_REQ-1:0][4:0] i_rd_addr,
    output logic                    o_a_vld,
    output logic [PTR_W-1:0]        o_a_idx,
    output logic                    o_b_vld,
    output logic [PTR_W-1:0]        o_b_idx
);

    logic [PTR_W:0] w_scan;

    always_comb begin
        o_a_vld = 1'b0;
        o_a_idx = '0;
        o_b_vld = 1'b0;
        o_b_idx = '0;
        w_scan  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_scan >= (PTR_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (PTR_W+1)'(NUM_REQ);
            end
            if (i_valid[w_scan[PTR_W-1:0]]) begin
                if (!o_a_vld) begin
                    o_a_vld = 1'b1;
                    o_a_idx = w_scan[PTR_W-1:0];
                // x0 never collides: writes to it are discarded anyway
                end else if (!o_b_vld &&
                             ((i_rd_addr[w_scan[PTR_W-1:0]] != i_rd_addr[o_a_idx]) ||
                              (i_rd_addr[w_scan[PTR_W-1:0]] == 5'd0) ||
                              (i_rd_addr[o_a_idx] == 5'd0))) begin
                    o_b_vld = 1'b1;
                    o_b_idx = w_scan[PTR_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module    : wb_port_arbiter                                           |
// | Brief     : Round-robin 2-of-N arbiter onto the regfile write ports.  |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
module wb_port_arbiter
    import aqua_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_hold,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ-1:0][4:0]  i_req_rd_addr,
    input  logic [NUM_REQ-1:0][31:0] i_req_data,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output writeback_t               o_wb_rf_pkg
);

    wb_req_t                  w_req [NUM_REQ];
    logic [NUM_REQ-1:0]       w_valid;
    logic [NUM_REQ-1:0][4:0]  w_rd;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        assign w_req[k]   = '{valid: i_req_valid[k], rd_addr: i_req_rd_addr[k], data: i_req_data[k]};
        assign w_valid[k] = w_req[k].valid;
        assign w_rd[k]    = w_req[k].rd_addr;
    end

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    writeback_t       wb_q, wb_d;
    logic             w_a_vld, w_b_vld;
    logic [PTR_W-1:0] w_a_idx, w_b_idx, w_last;
    logic [PTR_W:0]   w_inc;
    logic             w_go, w_grant_a, w_grant_b;

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_ptr     (rr_ptr_q),
        .i_valid   (w_valid),
        .i_rd_addr (w_rd),
        .o_a_vld   (w_a_vld),
        .o_a_idx   (w_a_idx),
        .o_b_vld   (w_b_vld),
        .o_b_idx   (w_b_idx)
    );

    // Reset gates ready too, so nothing is handshaken into a register about to clear
    assign w_go      = ~i_rst & ~i_hold;
    assign w_grant_a = w_a_vld & w_go;
    assign w_grant_b = w_b_vld & w_go;

    always_comb begin
        o_req_ready = '0;
        if (w_grant_a) o_req_ready[w_a_idx] = 1'b1;
        if (w_grant_b) o_req_ready[w_b_idx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        w_last   = w_grant_b ? w_b_idx : w_a_idx;
        w_inc    = {1'b0, w_last} + 1'b1;
        if (w_inc >= (PTR_W+1)'(NUM_REQ)) begin
            w_inc = '0;
        end
        if (w_grant_a) begin
            rr_ptr_d = w_inc[PTR_W-1:0];
        end
    end

    always_comb begin
        wb_d = '0;
        if (w_grant_a) begin
            wb_d.wren_instr1    = |w_req[w_a_idx].rd_addr;
            wb_d.rd_addr_instr1 = w_req[w_a_idx].rd_addr;
            wb_d.rd_data_instr1 = w_req[w_a_idx].data;
        end
        if (w_grant_b) begin
            wb_d.wren_instr2    = |w_req[w_b_idx].rd_addr;
            wb_d.rd_addr_instr2 = w_req[w_b_idx].rd_addr;
            wb_d.rd_data_instr2 = w_req[w_b_idx].data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
            wb_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wb_q     <= wb_d;
        end
    end

    assign o_wb_rf_pkg = wb_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module    : tb_wb_port_arbiter                                        |
// | Brief     : Directed + starvation bench with a scan-list model.       |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
module tb_wb_port_arbiter;
    import aqua_pkg::*;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                hold;
    logic [N-1:0]        valid;
    logic [N-1:0][4:0]   rd;
    logic [N-1:0][31:0]  data;
    logic [N-1:0]        ready;
    writeback_t          wb;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.NUM_REQ(N)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_hold        (hold),
        .i_req_valid   (valid),
        .i_req_rd_addr (rd),
        .i_req_data    (data),
        .o_req_ready   (ready),
        .o_wb_rf_pkg   (wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic writeback_t mk(input logic w1, input logic w2, input logic [4:0] a1,
                                      input logic [4:0] a2, input logic [31:0] d1, input logic [31:0] d2);
        writeback_t e;
        e = '0;
        e.wren_instr1 = w1;  e.wren_instr2 = w2;
        e.rd_addr_instr1 = a1; e.rd_addr_instr2 = a2;
        e.rd_data_instr1 = d1; e.rd_data_instr2 = d2;
        return e;
    endfunction

    // Model: list the valid requesters in priority order, A is the head,
    // B is the first later entry whose destination does not clash with A.
    int         m_ptr  = 0;
    writeback_t m_pkg  = '0;
    bit         m_live = 1'b0;

    always @(negedge clk) begin : model
        int         order[$];
        int         a, b, k;
        bit         ha, hb;
        logic [N-1:0] er;
        writeback_t nx;
        order.delete();
        ha = 0; hb = 0; a = 0; b = 0;
        if (!rst && !hold) begin
            for (int s = 0; s < N; s++) begin
                k = (m_ptr + s) % N;
                if (valid[k]) order.push_back(k);
            end
        end
        if (order.size() > 0) begin
            a = order[0]; ha = 1;
            for (int j = 1; j < order.size(); j++) begin
                if (!hb && (rd[order[j]] != rd[a] || rd[a] == 0 || rd[order[j]] == 0)) begin
                    b = order[j]; hb = 1;
                end
            end
        end
        er = '0;
        if (ha) er[a] = 1'b1;
        if (hb) er[b] = 1'b1;
        if (m_live) begin
            check("ready", 128'(ready), 128'(er));
            check("wb_pkg", 128'(wb), 128'(m_pkg));
            check("rr_ptr", 128'(dut.rr_ptr_q), 128'(m_ptr));
        end
        if (rst) begin
            m_ptr  = 0;
            m_pkg  = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            nx = '0;
            if (ha) begin
                nx.wren_instr1 = (rd[a] != 0); nx.rd_addr_instr1 = rd[a]; nx.rd_data_instr1 = data[a];
            end
            if (hb) begin
                nx.wren_instr2 = (rd[b] != 0); nx.rd_addr_instr2 = rd[b]; nx.rd_data_instr2 = data[b];
            end
            m_pkg = nx;
            if (ha) m_ptr = ((hb ? b : a) + 1) % N;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic base_reqs();
        for (int k = 0; k < N; k++) begin
            rd[k]   = 5'(k + 1);
            data[k] = 32'hA + 32'(k);
        end
    endtask

    initial begin : stim
        logic [N-1:0] g;
        int           wait3;
        rst = 1'b1; hold = 1'b0; valid = 4'b1111;
        base_reqs();
        tick(); tick();
        #1 check("rst_ready", 128'(ready), 128'(4'b0000));

        tick(); rst = 1'b0;
        #1 check("rr0_ready", 128'(ready), 128'(4'b0011));
        check("rst_wb", 128'(wb), 128'(0));
        tick(); valid = 4'b1100;
        #1 check("rr1_ready", 128'(ready), 128'(4'b1100));
        check("rr0_wb", 128'(wb), 128'(mk(1, 1, 5'd1, 5'd2, 32'hA, 32'hB)));
        tick(); valid = 4'b0000;
        #1 check("rr1_wb", 128'(wb), 128'(mk(1, 1, 5'd3, 5'd4, 32'hC, 32'hD)));
        check("ptr_wrap", 128'(dut.rr_ptr_q), 128'(0));

        tick(); valid = 4'b0101; rd[0] = 5'd7; rd[2] = 5'd7; data[0] = 32'h10; data[2] = 32'h12;
        #1 check("conf0_ready", 128'(ready), 128'(4'b0001));
        tick(); valid = 4'b0100;
        #1 check("conf1_ready", 128'(ready), 128'(4'b0100));
        check("conf0_wb", 128'(wb), 128'(mk(1, 0, 5'd7, 5'd0, 32'h10, 32'h0)));
        tick(); valid = 4'b0000;
        #1 check("conf1_wb", 128'(wb), 128'(mk(1, 0, 5'd7, 5'd0, 32'h12, 32'h0)));

        tick(); valid = 4'b0010; rd[1] = 5'd0; data[1] = 32'h55;
        #1 check("x0_ready", 128'(ready), 128'(4'b0010));
        tick(); valid = 4'b0000;
        #1 check("x0_wrens", 128'({wb.wren_instr1, wb.wren_instr2}), 128'(2'b00));

        base_reqs();
        tick(); valid = 4'b1111; hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1 check("hold_ready", 128'(ready), 128'(4'b0000));
            check("hold_wrens", 128'({wb.wren_instr1, wb.wren_instr2}), 128'(2'b00));
            check("hold_ptr", 128'(dut.rr_ptr_q), 128'(2));
        end
        tick(); hold = 1'b0;
        #1 check("release_ready", 128'(ready), 128'(4'b1100));
        tick(); valid = 4'b0011;
        #1 check("release2_ready", 128'(ready), 128'(4'b0011));
        tick(); valid = 4'b0000;

        tick(); valid = 4'b0001;
        #1 check("prerst_ready", 128'(ready), 128'(4'b0001));
        tick(); rst = 1'b1; valid = 4'b0000;
        #1 check("prerst_wb", 128'(wb), 128'(mk(1, 0, 5'd1, 5'd0, 32'hA, 32'h0)));
        tick(); rst = 1'b0;
        #1 check("midrst_wb", 128'(wb), 128'(0));
        check("midrst_ptr", 128'(dut.rr_ptr_q), 128'(0));

        g = '0; wait3 = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            for (int k = 0; k < N - 1; k++) begin
                if (!valid[k] || g[k]) begin
                    valid[k] = 1'($urandom_range(0, 1));
                    data[k]  = $urandom;
                end
            end
            if (g[3]) data[3] = $urandom;
            valid[3] = 1'b1;
            #1 g = ready;
            if (g[3]) begin
                check("starve_wait", 128'(wait3 < 2), 128'(1));
                wait3 = 0;
            end else begin
                wait3++;
            end
        end
        check("starve_final", 128'(wait3 < 2), 128'(1));

        tick(); valid = 4'b0000;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
